// File: rtl/operand_serializer_pkg.sv
// Shared definitions for the operand serializer: FSM state encoding and
// the helper that sizes the bit counter.
package operand_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/operand_serializer_if.sv
// Word-in / bit-out bus of the operand serializer.
// Handshake: a word is accepted on a rising edge where start = 1 and
// ready = 1; din is sampled on that same edge. start while ready = 0 is
// ignored. ser_out is meaningful only while ser_valid = 1, and done
// pulses for one cycle after the last payload bit of an accepted word.
interface operand_serializer_if
    import operand_serializer_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    modport master (
        output start, din,
        input  ready, ser_out, ser_valid, busy, done, dbg_state
    );

    modport slave (
        input  start, din,
        output ready, ser_out, ser_valid, busy, done, dbg_state
    );
endinterface

// File: rtl/operand_serializer_shift_reg.sv
// Datapath of the serializer: a WIDTH-bit register with parallel load and
// a one-position shift toward the output end. next_head_o is the bit that
// will sit at the output end after the coming edge, so the caller can
// register it alongside the shift register itself.
module shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             next_head_o
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next register value: load has priority over shift, otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = din_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
        end
    end

    // Register update with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign next_head_o = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
endmodule

// File: rtl/operand_serializer.sv
// Operand serializer: accepts a WIDTH-bit word when idle and shifts it out
// one bit per cycle, then pulses done for a single cycle before returning
// to idle. Every output comes straight from a flop.
module operand_serializer
    import operand_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr,
    operand_serializer_if.slave  bus
);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load, shift, next_head;
    logic          ser_out_q, ser_out_d;
    logic          ser_valid_q, ser_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk         (clk),
        .clr_i       (clr),
        .load_i      (load),
        .shift_i     (shift),
        .din_i       (bus.din),
        .next_head_o (next_head)
    );

    // Next-state, counter and datapath control; clr overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && ready_q) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    shift = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            load    = 1'b0;
            shift   = 1'b0;
        end
    end

    // Output values decoded from the next state so they can be registered.
    always_comb begin
        ser_valid_d = (state_d == ST_SHIFT);
        ser_out_d   = ser_valid_d && next_head;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        ready_d     = (state_d == ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ready     = ready_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: one LSB-first and one MSB-first instance,
// directed stimulus, per-instance expected-bit queues and cycle monitors.
module tb_operand_serializer;
    import operand_serializer_pkg::*;

    logic clk;
    logic clr;

    operand_serializer_if #(.WIDTH(8)) bl ();
    operand_serializer_if #(.WIDTH(8)) bm ();

    operand_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk), .clr (clr), .bus (bl)
    );
    operand_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk), .clr (clr), .bus (bm)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;
    logic exp_l[$];
    logic exp_m[$];
    int   l_bits = 0, m_bits = 0;
    int   l_dones = 0, m_dones = 0;
    logic l_done_prev = 1'b0, m_done_prev = 1'b0;
    logic e_l, e_m;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? bl.ready : bm.ready;
    endfunction

    task automatic wait_ready(input int which, input int max_cyc);
        int n = 0;
        while (rdy(which) !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        if (rdy(which) !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    endtask

    function automatic void push_word(input int which, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (which == 0) exp_l.push_back(d[i]);
            else            exp_m.push_back(d[7-i]);
        end
    endfunction

    // driver: present one word with a single-cycle start pulse
    task automatic send(input int which, input logic [7:0] d);
        check("accept_ready", 32'(rdy(which)), 32'd1);
        push_word(which, d);
        if (which == 0) begin bl.start = 1'b1; bl.din = d; end
        else            begin bm.start = 1'b1; bm.din = d; end
        step();
        if (which == 0) bl.start = 1'b0;
        else            bm.start = 1'b0;
    endtask

    // monitor / scoreboard for the LSB-first instance
    always @(negedge clk) begin
        if (chk_en) begin
            check("l_valid_implies_busy", 32'(bl.ser_valid && !bl.busy), 32'd0);
            check("l_ready_not_busy", 32'(bl.ready), 32'(!bl.busy));
            check("l_done_width", 32'(bl.done && l_done_prev), 32'd0);
            if (!bl.ser_valid) check("l_out_zero_idle", 32'(bl.ser_out), 32'd0);
            if (bl.done) begin
                check("l_bits_per_word", 32'(l_bits), 32'd8);
                l_dones++;
            end
            if (!bl.busy) l_bits = 0;
            if (bl.ser_valid) begin
                l_bits++;
                if (exp_l.size() == 0) begin
                    check("l_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e_l = exp_l.pop_front();
                    check("l_bit", 32'(bl.ser_out), 32'(e_l));
                end
            end
            l_done_prev = bl.done;
        end
    end

    // monitor / scoreboard for the MSB-first instance
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid_implies_busy", 32'(bm.ser_valid && !bm.busy), 32'd0);
            check("m_ready_not_busy", 32'(bm.ready), 32'(!bm.busy));
            check("m_done_width", 32'(bm.done && m_done_prev), 32'd0);
            if (!bm.ser_valid) check("m_out_zero_idle", 32'(bm.ser_out), 32'd0);
            if (bm.done) begin
                check("m_bits_per_word", 32'(m_bits), 32'd8);
                m_dones++;
            end
            if (!bm.busy) m_bits = 0;
            if (bm.ser_valid) begin
                m_bits++;
                if (exp_m.size() == 0) begin
                    check("m_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e_m = exp_m.pop_front();
                    check("m_bit", 32'(bm.ser_out), 32'(e_m));
                end
            end
            m_done_prev = bm.done;
        end
    end

    initial begin
        int d0;
        int acc[3];

        clr = 1'b1;
        bl.start = 1'b0; bl.din = '0;
        bm.start = 1'b0; bm.din = '0;
        step();
        step();
        clr = 1'b0;
        chk_en = 1'b1;

        // reset state
        check("rst_ready", 32'(bl.ready), 32'd1);
        check("rst_busy", 32'(bl.busy), 32'd0);
        check("rst_valid", 32'(bl.ser_valid), 32'd0);
        check("rst_out", 32'(bl.ser_out), 32'd0);
        check("rst_done", 32'(bl.done), 32'd0);
        check("rst_state", 32'(bl.dbg_state), 32'(ST_IDLE));
        check("rst_m_ready", 32'(bm.ready), 32'd1);

        // A5 LSB-first with exact latency
        d0 = l_dones;
        send(0, 8'hA5);
        for (int k = 0; k < 8; k++) begin
            check("a5_valid", 32'(bl.ser_valid), 32'd1);
            check("a5_state", 32'(bl.dbg_state), 32'(ST_SHIFT));
            step();
        end
        check("a5_done", 32'(bl.done), 32'd1);
        check("a5_done_valid", 32'(bl.ser_valid), 32'd0);
        check("a5_done_ready", 32'(bl.ready), 32'd0);
        step();
        check("a5_ready", 32'(bl.ready), 32'd1);
        check("a5_done_low", 32'(bl.done), 32'd0);
        check("a5_done_count", 32'(l_dones - d0), 32'd1);
        check("a5_queue_empty", 32'(exp_l.size()), 32'd0);

        // start while busy is ignored
        d0 = l_dones;
        send(0, 8'h0F);
        step();
        step();
        bl.start = 1'b1; bl.din = 8'hFF;
        step();
        bl.start = 1'b0; bl.din = 8'h00;
        check("busy_ignore_busy", 32'(bl.busy), 32'd1);
        wait_ready(0, 20);
        step();
        step();
        check("busy_ignore_idle", 32'(bl.busy), 32'd0);
        check("busy_ignore_dones", 32'(l_dones - d0), 32'd1);
        check("busy_ignore_queue", 32'(exp_l.size()), 32'd0);

        // clr in SHIFT cycle 4 aborts the word
        d0 = l_dones;
        send(0, 8'hC3);
        step();
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("abort_valid", 32'(bl.ser_valid), 32'd0);
        check("abort_busy", 32'(bl.busy), 32'd0);
        check("abort_ready", 32'(bl.ready), 32'd1);
        check("abort_state", 32'(bl.dbg_state), 32'(ST_IDLE));
        check("abort_left", 32'(exp_l.size()), 32'd4);
        exp_l.delete();
        step();
        step();
        check("abort_no_done", 32'(l_dones - d0), 32'd0);
        send(0, 8'h01);
        wait_ready(0, 20);
        check("after_abort_dones", 32'(l_dones - d0), 32'd1);
        check("after_abort_queue", 32'(exp_l.size()), 32'd0);

        // din changes after acceptance do not leak into the word
        d0 = l_dones;
        send(0, 8'h3C);
        bl.din = 8'h00;
        wait_ready(0, 20);
        check("din_hold_dones", 32'(l_dones - d0), 32'd1);
        check("din_hold_queue", 32'(exp_m.size() + exp_l.size()), 32'd0);

        // MSB-first, start held high: words 10 cycles apart
        d0 = m_dones;
        bm.din = 8'h81;
        bm.start = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_ready(1, 20);
            push_word(1, 8'h81);
            acc[w] = cyc;
            if (w > 0) check("b2b_spacing", 32'(acc[w] - acc[w-1]), 32'd10);
            step();
            if (w == 2) bm.start = 1'b0;
        end
        wait_ready(1, 20);
        check("b2b_dones", 32'(m_dones - d0), 32'd3);
        check("b2b_queue", 32'(exp_m.size()), 32'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per word (WIDTH >= 2).
REQ-002 Parameter MSB_FIRST, default 0; 0 = LSB shifted first, 1 = MSB shifted first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  load request; qualified only while ready = 1.
REQ-006 din  input  WIDTH  parallel word, sampled on the edge where start is accepted.
REQ-007 ready  output  1  high in IDLE only; a start is accepted when start = 1 and ready = 1.
REQ-008 ser_out  output  1  serial data bit, registered.
REQ-009 ser_valid  output  1  high on each cycle where ser_out carries a payload bit.
REQ-010 busy  output  1  high in SHIFT and DONE.
REQ-011 done  output  1  one-cycle pulse after the last payload bit.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; all outputs driven from registers.
REQ-013 IDLE -> SHIFT on an accepted start; din is captured into the shift register on that edge.
REQ-014 SHIFT lasts exactly WIDTH cycles; bit k (k = 0..WIDTH-1) is presented in SHIFT cycle k+1 after acceptance, with ser_valid = 1.
REQ-015 Bit order: for MSB_FIRST = 0, din[0] first, din[WIDTH-1] last; for MSB_FIRST = 1, the order is reversed.
REQ-016 The bit counter has width $clog2(WIDTH) and is cleared on acceptance; SHIFT -> DONE when the counter reaches WIDTH-1; no wrap past WIDTH-1.
REQ-017 DONE lasts exactly one cycle with done = 1, ser_valid = 0 and ser_out = 0; DONE -> IDLE unconditionally.
REQ-018 Latency: acceptance at edge T; first bit valid after T; done high in the cycle after edge T+WIDTH; ready high again after edge T+WIDTH+1.
REQ-019 start while busy (SHIFT or DONE) is ignored, with no effect on the shift register, counter or outputs.
REQ-020 din changes after acceptance do not affect the word in flight.
REQ-021 ser_out = 0 and ser_valid = 0 whenever the state is not SHIFT.
REQ-022 Back-to-back: start held high continuously produces one word every WIDTH+2 cycles, with exactly one idle (ready) cycle between done and the next first bit.

Reset
REQ-023 clr = 1 at a rising edge forces state IDLE, counter 0, shift register 0, ser_out 0, ser_valid 0, busy 0, done 0, ready 1 after that edge.
REQ-024 clr has priority over start and over every state transition.
REQ-025 clr asserted mid-SHIFT aborts the word; no done pulse is issued for the aborted word.
REQ-026 Until the first clr, output values are unspecified; the bench asserts clr before any checking.

Structure
REQ-027 The shared package holds the state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2) and the counter-width function.
REQ-028 One sub-module, shift_reg (WIDTH-bit, parallel load, shift enable, sync clr, direction parameter), holds the datapath; the FSM and counter live in operand_serializer.

Verification
REQ-029 WIDTH = 8, MSB_FIRST = 0: clr for 2 cycles, then start with din = 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 with ser_valid = 1 for 8 cycles, then done = 1 for one cycle, then ready = 1.
REQ-030 MSB_FIRST = 1, din = 8'h81, start held high -> bit sequences 1,0,0,0,0,0,0,1 repeated, with new words starting 10 cycles apart.
REQ-031 start pulsed during SHIFT cycle 3 with din = 8'hFF, word in flight 8'h0F -> output stays 1,1,1,1,0,0,0,0; exactly one done pulse.
REQ-032 clr asserted in SHIFT cycle 4 of 8'hC3 -> after that edge ser_valid = 0, busy = 0, ready = 1; no done pulse; the next start with 8'h01 serializes correctly.
REQ-033 din changed to 8'h00 one cycle after acceptance of 8'h3C -> serialized bits still 0,0,1,1,1,1,0,0.
REQ-034 Assertions throughout: done is only ever one cycle wide, ser_valid implies busy, ready equals not busy, and there are exactly WIDTH valid bits per accepted start.
